// File: rtl/lsu_lsq_pkg.sv
// lsu_lsq_pkg: LSQ slot lifecycle encoding and default field widths
// shared by the slot, its replay counter and the LSQ top.
package lsu_lsq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XLATE  = 3'd1,
    S_WAIT   = 3'd2,
    S_READY  = 3'd3,
    S_ISSUED = 3'd4,
    S_DONE   = 3'd5,
    S_EXC    = 3'd6
  } lsq_state_e;

  localparam int LSQ_XLEN       = 64;
  localparam int LSQ_VTAG_W     = 27;
  localparam int LSQ_TAG_W      = 44;
  localparam int LSQ_INDEX_W    = 6;
  localparam int LSQ_OFFSET_W   = 6;
  localparam int LSQ_ROB_IDX_W  = 6;
  localparam int LSQ_RD_W       = 5;
  localparam int LSQ_OPC_W      = 4;
  localparam int LSQ_ECAUSE_W   = 5;
  localparam int LSQ_REPLAY_W   = 3;
  localparam int LSQ_REPLAY_MAX = 6;

endpackage

// File: rtl/lsu_lsq_replay_ctr.sv
// lsu_lsq_replay_ctr: saturating replay counter with a starvation
// threshold; built only when LSU_LSQ_REPLAY_LIMIT_EN is defined.
module lsu_lsq_replay_ctr
  import lsu_lsq_pkg::*;
#(
  parameter int W   = LSQ_REPLAY_W,
  parameter int MAX = LSQ_REPLAY_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         starve
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt    = cnt_q;
  assign starve = (32'(cnt_q) >= MAX);

endmodule

// File: rtl/lsu_lsq_slot.sv
// lsu_lsq_slot: one LSQ entry from dispatch to dequeue.
// Define LSU_LSQ_REPLAY_LIMIT_EN to build the replay counter / starve flag.
module lsu_lsq_slot
  import lsu_lsq_pkg::*;
#(
  parameter int XLEN       = LSQ_XLEN,
  parameter int VTAG_W     = LSQ_VTAG_W,
  parameter int TAG_W      = LSQ_TAG_W,
  parameter int INDEX_W    = LSQ_INDEX_W,
  parameter int OFFSET_W   = LSQ_OFFSET_W,
  parameter int ROB_IDX_W  = LSQ_ROB_IDX_W,
  parameter int RD_W       = LSQ_RD_W,
  parameter int OPC_W      = LSQ_OPC_W,
  parameter int ECAUSE_W   = LSQ_ECAUSE_W,
  parameter int REPLAY_W   = LSQ_REPLAY_W,
  parameter int REPLAY_MAX = LSQ_REPLAY_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_i,
  input  logic                 alloc_ls_i,
  input  logic [OPC_W-1:0]     alloc_opcode_i,
  input  logic                 alloc_fenced_i,
  input  logic [VTAG_W-1:0]    alloc_vtag_i,
  input  logic [INDEX_W-1:0]   alloc_index_i,
  input  logic [OFFSET_W-1:0]  alloc_offset_i,
  input  logic [ROB_IDX_W-1:0] alloc_rob_idx_i,
  input  logic [RD_W-1:0]      alloc_rd_i,
  input  logic [XLEN-1:0]      alloc_data_i,
  input  logic                 alloc_exc_vld_i,
  input  logic [ECAUSE_W-1:0]  alloc_ecause_i,
  input  logic                 tlb_vld_i,
  input  logic [TAG_W-1:0]     tlb_tag_i,
  input  logic                 tlb_exc_vld_i,
  input  logic [ECAUSE_W-1:0]  tlb_ecause_i,
  input  logic                 wake_i,
  input  logic                 issue_i,
  input  logic                 replay_i,
  input  logic                 succ_i,
  input  logic                 dealloc_i,
  output logic                 vld_o,
  output logic [2:0]           state_o,
  output logic                 ready_o,
  output logic                 done_o,
  output logic                 ls_o,
  output logic [OPC_W-1:0]     opcode_o,
  output logic                 fenced_o,
  output logic [INDEX_W-1:0]   index_o,
  output logic [OFFSET_W-1:0]  offset_o,
  output logic [ROB_IDX_W-1:0] rob_idx_o,
  output logic [RD_W-1:0]      rd_o,
  output logic [XLEN-1:0]      data_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 virt_o,
  output logic                 exc_vld_o,
  output logic [ECAUSE_W-1:0]  ecause_o,
  output logic [REPLAY_W-1:0]  replay_cnt_o,
  output logic                 starve_o
);

  typedef struct packed {
    logic                 ls;
    logic [OPC_W-1:0]     opcode;
    logic                 fenced;
    logic [TAG_W-1:0]     tag;
    logic                 virt;
    logic [INDEX_W-1:0]   index;
    logic [OFFSET_W-1:0]  offset;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [RD_W-1:0]      rd;
    logic [XLEN-1:0]      data;
    logic                 exc_vld;
    logic [ECAUSE_W-1:0]  ecause;
    logic                 awake;
  } slot_t;

  lsq_state_e state_q, state_d;
  slot_t      slot_q, slot_d;
  logic       woke;

  // Wakeup may arrive in the same cycle as the event that consumes it.
  assign woke = slot_q.awake | wake_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (flush) begin
      state_d = S_IDLE;
      slot_d  = '0;
    end else if (alloc_i) begin
      slot_d.ls      = alloc_ls_i;
      slot_d.opcode  = alloc_opcode_i;
      slot_d.fenced  = alloc_fenced_i;
      slot_d.tag     = TAG_W'(alloc_vtag_i);
      slot_d.virt    = 1'b1;
      slot_d.index   = alloc_index_i;
      slot_d.offset  = alloc_offset_i;
      slot_d.rob_idx = alloc_rob_idx_i;
      slot_d.rd      = alloc_rd_i;
      slot_d.data    = alloc_data_i;
      slot_d.exc_vld = alloc_exc_vld_i;
      slot_d.ecause  = alloc_ecause_i;
      slot_d.awake   = 1'b0;
      state_d = alloc_exc_vld_i ? S_EXC : S_XLATE;
    end else if (dealloc_i) begin
      state_d = S_IDLE;
    end else begin
      if (state_q != S_IDLE && wake_i) begin
        slot_d.awake = 1'b1;
      end
      unique case (state_q)
        S_XLATE: begin
          if (tlb_vld_i && tlb_exc_vld_i) begin
            slot_d.exc_vld = 1'b1;
            slot_d.ecause  = tlb_ecause_i;
            state_d = S_EXC;
          end else if (tlb_vld_i) begin
            slot_d.tag  = tlb_tag_i;
            slot_d.virt = 1'b0;
            state_d = woke ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          if (woke) state_d = S_READY;
        end
        S_READY: begin
          if (issue_i) state_d = S_ISSUED;
        end
        S_ISSUED: begin
          if (replay_i)    state_d = S_READY;
          else if (succ_i) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  assign vld_o     = (state_q != S_IDLE);
  assign state_o   = state_q;
  assign ready_o   = (state_q == S_READY);
  assign done_o    = (state_q == S_DONE);
  assign ls_o      = slot_q.ls;
  assign opcode_o  = slot_q.opcode;
  assign fenced_o  = slot_q.fenced;
  assign index_o   = slot_q.index;
  assign offset_o  = slot_q.offset;
  assign rob_idx_o = slot_q.rob_idx;
  assign rd_o      = slot_q.rd;
  assign data_o    = slot_q.data;
  assign tag_o     = slot_q.tag;
  assign virt_o    = slot_q.virt;
  assign exc_vld_o = slot_q.exc_vld;
  assign ecause_o  = slot_q.ecause;

`ifdef LSU_LSQ_REPLAY_LIMIT_EN
  logic replay_hit;

  // A same-cycle dealloc outranks the replay.
  assign replay_hit = (state_q == S_ISSUED) & replay_i & ~dealloc_i;

  lsu_lsq_replay_ctr #(
    .W   (REPLAY_W),
    .MAX (REPLAY_MAX)
  ) u_replay_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush | alloc_i),
    .inc    (replay_hit),
    .cnt    (replay_cnt_o),
    .starve (starve_o)
  );
`else
  logic unused_max;

  assign unused_max   = |REPLAY_MAX;
  assign replay_cnt_o = '0;
  assign starve_o     = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_lsq_slot.sv
// tb_lsu_lsq_slot: scoreboard bench for lsu_lsq_slot (directed plan
// followed by random traffic against a behavioural slot model).
module tb_lsu_lsq_slot;

  localparam int XLEN = 64, VTAG_W = 27, TAG_W = 44;
  localparam int INDEX_W = 6, OFFSET_W = 6, ROB_IDX_W = 6;
  localparam int RD_W = 5, OPC_W = 4, ECAUSE_W = 5;
  localparam int REPLAY_W = 3, REPLAY_MAX = 6;
`ifdef LSU_LSQ_REPLAY_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  localparam int IDLE = 0, XLATE = 1, WAIT = 2, READY = 3;
  localparam int ISSUED = 4, DONE = 5, EXC = 6;

  logic clk, rst, flush;
  logic alloc_i, alloc_ls_i, alloc_fenced_i, alloc_exc_vld_i;
  logic [OPC_W-1:0] alloc_opcode_i;
  logic [VTAG_W-1:0] alloc_vtag_i;
  logic [INDEX_W-1:0] alloc_index_i;
  logic [OFFSET_W-1:0] alloc_offset_i;
  logic [ROB_IDX_W-1:0] alloc_rob_idx_i;
  logic [RD_W-1:0] alloc_rd_i;
  logic [XLEN-1:0] alloc_data_i;
  logic [ECAUSE_W-1:0] alloc_ecause_i, tlb_ecause_i;
  logic tlb_vld_i, tlb_exc_vld_i, wake_i, issue_i;
  logic replay_i, succ_i, dealloc_i;
  logic [TAG_W-1:0] tlb_tag_i;

  logic vld_o, ready_o, done_o, ls_o, fenced_o, virt_o;
  logic exc_vld_o, starve_o;
  logic [2:0] state_o;
  logic [OPC_W-1:0] opcode_o;
  logic [INDEX_W-1:0] index_o;
  logic [OFFSET_W-1:0] offset_o;
  logic [ROB_IDX_W-1:0] rob_idx_o;
  logic [RD_W-1:0] rd_o;
  logic [XLEN-1:0] data_o;
  logic [TAG_W-1:0] tag_o;
  logic [ECAUSE_W-1:0] ecause_o;
  logic [REPLAY_W-1:0] replay_cnt_o;

  lsu_lsq_slot dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_i(alloc_i), .alloc_ls_i(alloc_ls_i),
    .alloc_opcode_i(alloc_opcode_i),
    .alloc_fenced_i(alloc_fenced_i),
    .alloc_vtag_i(alloc_vtag_i),
    .alloc_index_i(alloc_index_i),
    .alloc_offset_i(alloc_offset_i),
    .alloc_rob_idx_i(alloc_rob_idx_i),
    .alloc_rd_i(alloc_rd_i), .alloc_data_i(alloc_data_i),
    .alloc_exc_vld_i(alloc_exc_vld_i),
    .alloc_ecause_i(alloc_ecause_i),
    .tlb_vld_i(tlb_vld_i), .tlb_tag_i(tlb_tag_i),
    .tlb_exc_vld_i(tlb_exc_vld_i), .tlb_ecause_i(tlb_ecause_i),
    .wake_i(wake_i), .issue_i(issue_i), .replay_i(replay_i),
    .succ_i(succ_i), .dealloc_i(dealloc_i),
    .vld_o(vld_o), .state_o(state_o), .ready_o(ready_o),
    .done_o(done_o), .ls_o(ls_o), .opcode_o(opcode_o),
    .fenced_o(fenced_o), .index_o(index_o),
    .offset_o(offset_o), .rob_idx_o(rob_idx_o), .rd_o(rd_o),
    .data_o(data_o), .tag_o(tag_o), .virt_o(virt_o),
    .exc_vld_o(exc_vld_o), .ecause_o(ecause_o),
    .replay_cnt_o(replay_cnt_o), .starve_o(starve_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic vld; logic [2:0] st; logic rdy; logic done;
    logic ls; logic [OPC_W-1:0] opc; logic fenced;
    logic [TAG_W-1:0] tag; logic virt;
    logic [INDEX_W-1:0] idx; logic [OFFSET_W-1:0] off;
    logic [ROB_IDX_W-1:0] rob; logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data; logic exc; logic [ECAUSE_W-1:0] ec;
    logic [REPLAY_W-1:0] cnt; logic starve; logic known;
  } exp_t;

  exp_t exp_q[$];
  exp_t mf;
  int m_st, m_cnt;
  bit m_awake;
  int checks = 0, failures = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic check_all(exp_t e);
    chk("state", 64'(state_o), 64'(e.st));
    chk("vld", 64'(vld_o), 64'(e.vld));
    chk("ready", 64'(ready_o), 64'(e.rdy));
    chk("done", 64'(done_o), 64'(e.done));
    chk("replay_cnt", 64'(replay_cnt_o), 64'(e.cnt));
    chk("starve", 64'(starve_o), 64'(e.starve));
    // After a dequeue the stored fields are don't-care.
    if (e.known) begin
      chk("ls", 64'(ls_o), 64'(e.ls));
      chk("opcode", 64'(opcode_o), 64'(e.opc));
      chk("fenced", 64'(fenced_o), 64'(e.fenced));
      chk("tag", 64'(tag_o), 64'(e.tag));
      chk("virt", 64'(virt_o), 64'(e.virt));
      chk("index", 64'(index_o), 64'(e.idx));
      chk("offset", 64'(offset_o), 64'(e.off));
      chk("rob_idx", 64'(rob_idx_o), 64'(e.rob));
      chk("rd", 64'(rd_o), 64'(e.rd));
      chk("data", data_o, e.data);
      chk("exc_vld", 64'(exc_vld_o), 64'(e.exc));
      chk("ecause", 64'(ecause_o), 64'(e.ec));
    end
  endtask

  task automatic model_reset();
    mf = '{default: '0};
    mf.known = 1'b1;
    m_st = IDLE;
    m_cnt = 0;
    m_awake = 1'b0;
  endtask

  function automatic exp_t mk_exp();
    exp_t e;
    e = mf;
    e.st = 3'(m_st);
    e.vld = (m_st != IDLE);
    e.rdy = (m_st == READY);
    e.done = (m_st == DONE);
    e.cnt = LIM ? REPLAY_W'(m_cnt) : '0;
    e.starve = LIM && (m_cnt >= REPLAY_MAX);
    return e;
  endfunction

  // Next-cycle slot contents given the inputs now on the pins.
  task automatic model_step();
    bit woke;
    if (flush) begin
      model_reset();
    end else if (alloc_i) begin
      mf.ls = alloc_ls_i; mf.opc = alloc_opcode_i;
      mf.fenced = alloc_fenced_i;
      mf.tag = TAG_W'(alloc_vtag_i); mf.virt = 1'b1;
      mf.idx = alloc_index_i; mf.off = alloc_offset_i;
      mf.rob = alloc_rob_idx_i; mf.rd = alloc_rd_i;
      mf.data = alloc_data_i;
      mf.exc = alloc_exc_vld_i; mf.ec = alloc_ecause_i;
      mf.known = 1'b1;
      m_awake = 1'b0;
      m_cnt = 0;
      m_st = alloc_exc_vld_i ? EXC : XLATE;
    end else if (dealloc_i) begin
      if (m_st != IDLE) begin
        m_st = IDLE;
        mf.known = 1'b0;
      end
    end else begin
      woke = m_awake || (wake_i && m_st != IDLE);
      if (m_st == XLATE && tlb_vld_i) begin
        if (tlb_exc_vld_i) begin
          mf.exc = 1'b1; mf.ec = tlb_ecause_i; m_st = EXC;
        end else begin
          mf.tag = tlb_tag_i; mf.virt = 1'b0;
          m_st = woke ? READY : WAIT;
        end
      end else if (m_st == WAIT && woke) begin
        m_st = READY;
      end else if (m_st == READY && issue_i) begin
        m_st = ISSUED;
      end else if (m_st == ISSUED && replay_i) begin
        m_st = READY;
        if (m_cnt < (1 << REPLAY_W) - 1) m_cnt++;
      end else if (m_st == ISSUED && succ_i) begin
        m_st = DONE;
      end
      m_awake = woke;
    end
  endtask

  task automatic idle_ctl();
    flush = 0; alloc_i = 0; alloc_exc_vld_i = 0;
    tlb_vld_i = 0; tlb_exc_vld_i = 0; wake_i = 0;
    issue_i = 0; replay_i = 0; succ_i = 0; dealloc_i = 0;
  endtask

  task automatic nx();
    @(negedge clk);
    idle_ctl();
  endtask

  task automatic go();
    model_step();
    exp_q.push_back(mk_exp());
  endtask

  task automatic rand_fields();
    alloc_ls_i = 1'($urandom); alloc_opcode_i = OPC_W'($urandom);
    alloc_fenced_i = 1'($urandom);
    alloc_vtag_i = VTAG_W'($urandom);
    alloc_index_i = INDEX_W'($urandom);
    alloc_offset_i = OFFSET_W'($urandom);
    alloc_rob_idx_i = ROB_IDX_W'($urandom);
    alloc_rd_i = RD_W'($urandom);
    alloc_data_i = {$urandom, $urandom};
    alloc_ecause_i = ECAUSE_W'($urandom);
    tlb_tag_i = TAG_W'({$urandom, $urandom});
    tlb_ecause_i = ECAUSE_W'($urandom);
  endtask

  task automatic do_alloc(bit exc);
    rand_fields();
    alloc_i = 1'b1;
    alloc_exc_vld_i = exc;
  endtask

  // Scoreboard monitor: one expected entry per driven cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all(e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t z;
    rst = 1'b1;
    idle_ctl();
    rand_fields();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    nx(); go();

    nx(); do_alloc(0); alloc_vtag_i = 27'h1234; go();
    nx(); tlb_vld_i = 1; tlb_tag_i = 44'hABCDE; go();
    nx(); wake_i = 1; go();

    nx(); issue_i = 1; go();
    nx(); replay_i = 1; succ_i = 1; issue_i = 1; go();
    for (int i = 0; i < 8; i++) begin
      nx(); issue_i = 1; go();
      nx(); replay_i = 1; go();
    end

    nx(); do_alloc(0); go();
    nx(); tlb_vld_i = 1; tlb_exc_vld_i = 1;
    tlb_ecause_i = 5'd13; go();
    nx(); issue_i = 1; tlb_vld_i = 1; go();
    nx(); dealloc_i = 1; go();

    nx(); do_alloc(0); wake_i = 1; go();
    nx(); tlb_vld_i = 1; go();
    nx(); wake_i = 1; go();
    nx(); issue_i = 1; go();
    nx(); succ_i = 1; go();
    nx(); do_alloc(0); dealloc_i = 1; go();

    nx(); tlb_vld_i = 1; wake_i = 1; go();
    nx(); issue_i = 1; go();
    @(posedge clk);
    #3;
    idle_ctl();
    rst = 1'b1;
    #1;
    model_reset();
    z = mk_exp();
    check_all(z);
    @(negedge clk);
    rst = 1'b0;

    nx(); do_alloc(0); go();
    nx(); tlb_vld_i = 1; wake_i = 1; go();
    nx(); flush = 1; go();
    nx(); go();

    for (int i = 0; i < 3000; i++) begin
      nx();
      rand_fields();
      flush = ($urandom_range(99) < 3);
      alloc_i = ($urandom_range(99) < 10);
      alloc_exc_vld_i = ($urandom_range(99) < 10);
      dealloc_i = ($urandom_range(99) < 8);
      tlb_vld_i = ($urandom_range(99) < 35);
      tlb_exc_vld_i = ($urandom_range(99) < 15);
      wake_i = ($urandom_range(99) < 25);
      issue_i = ($urandom_range(99) < 50);
      replay_i = ($urandom_range(99) < 30);
      succ_i = ($urandom_range(99) < 50);
      go();
    end

    nx(); go();
    @(posedge clk);
    #2;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_lsq_slot.md
Name: lsu_lsq_slot

Overview:
- Parametrised load/store-queue slot with an explicit lifecycle FSM; the next generation of the per-entry LSQ storage in lsuv1.
- Holds one memory op from dispatch to dequeue: virtual-to-physical tag swap, wakeup, issue/replay tracking and exception capture.
- Adds a replay counter and a starvation flag that the previous entry lacked.
- Instantiated NUM_ENTRIES times by the LSQ. The LSQ's select logic reads ready_o; the ROB/commit path reads done_o/exc_vld_o.

Parameters:
XLEN, 64, data width
VTAG_W, 27, virtual tag width
TAG_W, 44, physical tag width (>= VTAG_W)
INDEX_W, 6, cache index width
OFFSET_W, 6, line offset width
ROB_IDX_W, 6, ROB index width
RD_W, 5, destination register address width
OPC_W, 4, opcode width
ECAUSE_W, 5, exception cause width
REPLAY_W, 3, replay counter width
REPLAY_MAX, 6, replay count at which starve_o asserts (<= 2^REPLAY_W-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous pipeline flush
alloc_i  in  1  allocate slot with fields below
alloc_ls_i  in  1  0=load 1=store
alloc_opcode_i  in  OPC_W  opcode
alloc_fenced_i  in  1  fence-ordered op
alloc_vtag_i  in  VTAG_W  virtual tag
alloc_index_i  in  INDEX_W  index
alloc_offset_i  in  OFFSET_W  offset
alloc_rob_idx_i  in  ROB_IDX_W  ROB index
alloc_rd_i  in  RD_W  rd address
alloc_data_i  in  XLEN  store data
alloc_exc_vld_i  in  1  exception at dispatch
alloc_ecause_i  in  ECAUSE_W  dispatch cause
tlb_vld_i  in  1  translation response
tlb_tag_i  in  TAG_W  physical tag
tlb_exc_vld_i  in  1  translation fault
tlb_ecause_i  in  ECAUSE_W  fault cause
wake_i  in  1  operand/ordering wakeup
issue_i  in  1  slot issued to cache
replay_i  in  1  issued op must replay
succ_i  in  1  issued op completed
dealloc_i  in  1  dequeue
vld_o  out  1  slot occupied
state_o  out  3  FSM state
ready_o  out  1  state==READY
done_o  out  1  state==DONE
ls_o, opcode_o, fenced_o, index_o, offset_o, rob_idx_o, rd_o, data_o  out  as inputs  stored fields
tag_o  out  TAG_W  vtag zero-extended until translated, then ptag
virt_o  out  1  tag_o still virtual
exc_vld_o  out  1  exception captured
ecause_o  out  ECAUSE_W  cause
replay_cnt_o  out  REPLAY_W  replays since alloc
starve_o  out  1  replay_cnt_o >= REPLAY_MAX

Behaviour:
- Reset (async) and flush (sync) force state IDLE and clear every register. All outputs reset to 0; state_o=IDLE=0.
- States: IDLE=0, XLATE=1, WAIT=2, READY=3, ISSUED=4, DONE=5, EXC=6.
- Priority per cycle: flush > alloc > dealloc > tlb/wake/issue/replay/succ.
- alloc_i in any state: latch all fields; virt=1; tag={0,vtag}; awake=0; cnt=0. Next state EXC if alloc_exc_vld_i, else XLATE.
- alloc+dealloc in the same cycle reallocates (back-to-back reuse).
- dealloc_i in any non-IDLE state -> IDLE next cycle, vld_o=0.
- awake flag: set by wake_i in any valid state, cleared only on alloc.
- XLATE + tlb_vld_i:
  - fault: exc/ecause <- tlb values, -> EXC.
  - no fault: tag<=tlb_tag_i, virt<=0, -> READY if awake (or wake_i this cycle), else WAIT.
- WAIT -> READY on awake.
- READY -> ISSUED on issue_i.
- ISSUED:
  - replay_i -> READY and cnt++ (saturating at all-ones); replay beats succ_i and issue_i.
  - else succ_i -> DONE.
- DONE and EXC hold until dealloc/flush.
- Ignored inputs, no state change:
  - tlb_vld_i outside XLATE
  - issue_i outside READY
  - replay_i/succ_i outside ISSUED
- All outputs registered; every transition is visible one cycle after the input.

Optional Feature:
LSU_LSQ_REPLAY_LIMIT_EN
- Defined: replay counter and starve_o behave as above.
- Undefined: no counter flops; replay_cnt_o=0 and starve_o=0 constant; replay still returns ISSUED->READY.

Decomposition:
- Package lsu_lsq_pkg holds the state encoding constants (IDLE..EXC, 3-bit) and default width constants shared with the LSQ top.
- One natural sub-module: lsu_lsq_replay_ctr, a saturating counter plus threshold compare. It sits inside the `ifdef.

Test Plan:
- Alloc vtag=0x1234, no fault; next cycle tlb ptag=0xABCDE; wake_i -> state XLATE->WAIT->READY, tag_o=0xABCDE, virt_o=0.
- READY, issue_i; then replay_i together with succ_i -> state READY, replay_cnt_o=1, not DONE.
- With LSU_LSQ_REPLAY_LIMIT_EN, 6 issue/replay loops -> starve_o=1 at cnt=6; cnt saturates at 7 after 9 loops.
- XLATE + tlb_exc_vld_i with cause 13 -> EXC, exc_vld_o=1, ecause_o=13; dealloc -> IDLE, vld_o=0.
- DONE + alloc & dealloc in the same cycle -> XLATE with the new fields, cnt=0, awake=0.
- rst asserted mid-ISSUED, asynchronously between edges -> all outputs 0 immediately; flush in READY -> IDLE next edge.
